// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator with a single start/done request port.
// One access in flight at a time; all AXI outputs come from flops.

module axi4_lite_master #(
    parameter int         AXI_ADDR_WIDTH = 64,
    parameter int         AXI_DATA_WIDTH = 32,
    parameter logic [2:0] AXI_PROT       = 3'b000
) (
    input  logic                        clk_i,
    input  logic                        arst_i,

    input  logic                        start_read_i,
    input  logic                        start_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] strb_i,
    output logic [AXI_DATA_WIDTH-1:0]   data_o,
    output logic [1:0]                  resp_o,
    output logic                        read_done_o,
    output logic                        write_done_o,
    output logic                        busy_o,

    output logic                        AR_VALID,
    output logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
    output logic [2:0]                  AR_PROT,
    input  logic                        AR_READY,

    input  logic [AXI_DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]                  R_RESP,
    input  logic                        R_VALID,
    output logic                        R_READY,

    output logic                        AW_VALID,
    output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
    output logic [2:0]                  AW_PROT,
    input  logic                        AW_READY,

    output logic                        W_VALID,
    output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
    output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
    input  logic                        W_READY,

    input  logic [1:0]                  B_RESP,
    input  logic                        B_VALID,
    output logic                        B_READY
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR_DATA,
        ST_WR_RESP
    } state_e;

    state_e                    state_q, state_d;

    logic                      ar_valid_q, ar_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                      r_ready_q, r_ready_d;

    logic                      aw_valid_q, aw_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                      w_valid_q, w_valid_d;
    logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]         w_strb_q, w_strb_d;
    logic                      b_ready_q, b_ready_d;

    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]                resp_q, resp_d;
    logic                      rd_done_q, rd_done_d;
    logic                      wr_done_q, wr_done_d;

    // Address and data channels still waiting for their handshake.
    logic                      aw_pend;
    logic                      w_pend;

    // Next-state and next-output logic for the shared read/write FSM.
    always_comb begin
        state_d    = state_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        r_ready_d  = r_ready_q;
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_ready_d  = b_ready_q;
        data_d     = data_q;
        resp_d     = resp_q;
        rd_done_d  = 1'b0;
        wr_done_d  = 1'b0;
        aw_pend    = aw_valid_q && !AW_READY;
        w_pend     = w_valid_q && !W_READY;

        unique case (state_q)
            ST_IDLE: begin
                // A simultaneous write request is dropped, not queued.
                if (start_read_i) begin
                    state_d    = ST_RD_ADDR;
                    ar_valid_d = 1'b1;
                    ar_addr_d  = addr_i;
                end else if (start_write_i) begin
                    state_d    = ST_WR_ADDR_DATA;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    aw_addr_d  = addr_i;
                    w_data_d   = data_i;
                    w_strb_d   = strb_i;
                end
            end

            ST_RD_ADDR: begin
                if (ar_valid_q && AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (R_VALID && r_ready_q) begin
                    data_d    = R_DATA;
                    resp_d    = R_RESP;
                    r_ready_d = 1'b0;
                    rd_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_WR_ADDR_DATA: begin
                // Each channel retires on its own handshake.
                aw_valid_d = aw_pend;
                w_valid_d  = w_pend;
                if (!aw_pend && !w_pend) begin
                    b_ready_d = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (B_VALID && b_ready_q) begin
                    resp_d    = B_RESP;
                    b_ready_d = 1'b0;
                    wr_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read address and read data channel registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            r_ready_q  <= r_ready_d;
        end
    end

    // Write address, write data and write response channel registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_ready_q  <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_ready_q  <= b_ready_d;
        end
    end

    // Requester-side result registers and completion pulses.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q    <= '0;
            resp_q    <= 2'b00;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            resp_q    <= resp_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign AR_VALID     = ar_valid_q;
    assign AR_ADDR      = ar_addr_q;
    assign AR_PROT      = AXI_PROT;
    assign R_READY      = r_ready_q;

    assign AW_VALID     = aw_valid_q;
    assign AW_ADDR      = aw_addr_q;
    assign AW_PROT      = AXI_PROT;
    assign W_VALID      = w_valid_q;
    assign W_DATA       = w_data_q;
    assign W_STRB       = w_strb_q;
    assign B_READY      = b_ready_q;

    assign data_o       = data_q;
    assign resp_o       = resp_q;
    assign read_done_o  = rd_done_q;
    assign write_done_o = wr_done_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: directed scenarios plus a randomized run
// against a word-level memory model and an AXI slave with random waits.
`timescale 1ns/1ps

module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        arst_i = 1'b1;
    logic        start_read_i = 1'b0;
    logic        start_write_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  strb_i = '0;
    logic [31:0] data_o;
    logic [1:0]  resp_o;
    logic        read_done_o, write_done_o, busy_o;
    logic        AR_VALID, AR_READY = 1'b0;
    logic [63:0] AR_ADDR, AW_ADDR;
    logic [2:0]  AR_PROT, AW_PROT;
    logic [31:0] R_DATA = '0;
    logic [1:0]  R_RESP = '0;
    logic        R_VALID = 1'b0, R_READY;
    logic        AW_VALID, AW_READY = 1'b0;
    logic        W_VALID, W_READY = 1'b0;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic [1:0]  B_RESP = '0;
    logic        B_VALID = 1'b0, B_READY;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4_lite_master dut (
        .clk_i(clk), .arst_i(arst_i),
        .start_read_i(start_read_i), .start_write_i(start_write_i),
        .addr_i(addr_i), .data_i(data_i), .strb_i(strb_i),
        .data_o(data_o), .resp_o(resp_o),
        .read_done_o(read_done_o), .write_done_o(write_done_o),
        .busy_o(busy_o),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
        .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID),
        .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
        .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_STRB(W_STRB),
        .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
    );

    // Slave configuration: wait cycles per channel and responses.
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0]  r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;

    // Slave byte memory and bookkeeping.
    logic [7:0]  smem [logic [63:0]];
    int          s_aw_hs_cnt = 0;
    logic [63:0] s_last_wa = '0;
    logic [31:0] s_last_wd = '0;
    logic [3:0]  s_last_ws = '0;

    // Reference model: word memory.
    logic [31:0] mdl [logic [63:0]];

    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    bit          rd_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
    logic [63:0] rd_addr = '0, wa = '0;
    logic [31:0] wd = '0;
    logic [3:0]  ws = '0;

    function automatic logic [31:0] dflt(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32];
    endfunction

    function automatic logic [31:0] s_read(input logic [63:0] a);
        logic [31:0] d, r;
        d = dflt(a);
        for (int k = 0; k < 4; k++) begin
            if (smem.exists(a + 64'(k))) r[k*8 +: 8] = smem[a + 64'(k)];
            else r[k*8 +: 8] = d[k*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [63:0] a);
        return mdl.exists(a) ? mdl[a] : dflt(a);
    endfunction

    // Behavioural AXI4-Lite slave: sample handshakes at the edge,
    // drive new ready/valid shortly after it.
    always @(posedge clk) begin
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
        ar_hs = AR_VALID && AR_READY;
        r_hs  = R_VALID && R_READY;
        aw_hs = AW_VALID && AW_READY;
        w_hs  = W_VALID && W_READY;
        b_hs  = B_VALID && B_READY;
        if (!arst_i) begin
            if (ar_hs) begin
                rd_pend = 1; rd_addr = AR_ADDR; r_wait = 0; ar_wait = 0;
            end
            if (r_hs) rd_pend = 0;
            if (aw_hs) begin
                aw_got = 1; wa = AW_ADDR; aw_wait = 0; s_aw_hs_cnt++;
            end
            if (w_hs) begin
                w_got = 1; wd = W_DATA; ws = W_STRB; w_wait = 0;
            end
            if (b_hs) begin
                for (int k = 0; k < 4; k++)
                    if (ws[k]) smem[wa + 64'(k)] = wd[k*8 +: 8];
                s_last_wa = wa; s_last_wd = wd; s_last_ws = ws;
                b_pend = 0; aw_got = 0; w_got = 0;
            end else if (aw_got && w_got && !b_pend) begin
                b_pend = 1; b_wait = 0;
            end
        end
        #1;
        if (arst_i) begin
            rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
            ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
            AR_READY = 0; R_VALID = 0; AW_READY = 0; W_READY = 0; B_VALID = 0;
        end else begin
            if (!AR_VALID) ar_wait = 0;
            AR_READY = AR_VALID && (ar_wait >= ar_dly);
            if (AR_VALID && !AR_READY) ar_wait++;
            if (!AW_VALID) aw_wait = 0;
            AW_READY = AW_VALID && (aw_wait >= aw_dly);
            if (AW_VALID && !AW_READY) aw_wait++;
            if (!W_VALID) w_wait = 0;
            W_READY = W_VALID && (w_wait >= w_dly);
            if (W_VALID && !W_READY) w_wait++;
            if (rd_pend) begin
                if (r_wait >= r_dly) begin
                    R_VALID = 1; R_DATA = s_read(rd_addr); R_RESP = r_resp_cfg;
                end else begin
                    R_VALID = 0; r_wait++;
                end
            end else R_VALID = 0;
            if (b_pend) begin
                if (b_wait >= b_dly) begin
                    B_VALID = 1; B_RESP = b_resp_cfg;
                end else begin
                    B_VALID = 0; b_wait++;
                end
            end else B_VALID = 0;
        end
    end

    task automatic set_dly(input int a, input int r, input int aw,
                           input int w, input int b);
        ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    task automatic preload_1000();
        smem[64'h1000] = 8'hEF; smem[64'h1001] = 8'hBE;
        smem[64'h1002] = 8'hAD; smem[64'h1003] = 8'hDE;
    endtask

    task automatic test_reset();
        arst_i = 1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY,
             read_done_o, write_done_o, busy_o} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 00000000", {AR_VALID, R_READY,
                     AW_VALID, W_VALID, B_READY, read_done_o, write_done_o, busy_o});
        end
        n_vec++;
        if (data_o !== 32'h0 || resp_o !== 2'b00) begin
            n_err++;
            $display("FAIL reset_result got data=%h resp=%b want 0", data_o, resp_o);
        end
        n_vec++;
        if (AR_ADDR !== 64'h0 || AW_ADDR !== 64'h0 || W_DATA !== 32'h0
            || W_STRB !== 4'h0) begin
            n_err++;
            $display("FAIL reset_payload got ar=%h aw=%h wd=%h ws=%h want 0",
                     AR_ADDR, AW_ADDR, W_DATA, W_STRB);
        end
        n_vec++;
        if (AR_PROT !== 3'b000 || AW_PROT !== 3'b000) begin
            n_err++;
            $display("FAIL prot got %b/%b want 000", AR_PROT, AW_PROT);
        end
        arst_i = 0;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        preload_1000();
        set_dly(0, 0, 0, 0, 0);
        r_resp_cfg = 2'b00;
        addr_i = 64'h1000; start_read_i = 1;
        @(negedge clk);
        start_read_i = 0; addr_i = 64'hFFFF_0000_1234_5678;
        n_vec++;
        if (AR_VALID !== 1'b1 || AR_ADDR !== 64'h1000) begin
            n_err++;
            $display("FAIL rd_basic_c1 got v=%b a=%h want 1/1000", AR_VALID, AR_ADDR);
        end
        @(negedge clk);
        n_vec++;
        if (R_READY !== 1'b1 || AR_VALID !== 1'b0 || read_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL rd_basic_c2 got rr=%b arv=%b done=%b want 1/0/0",
                     R_READY, AR_VALID, read_done_o);
        end
        @(negedge clk);
        n_vec++;
        if (read_done_o !== 1'b1 || data_o !== 32'hDEADBEEF || resp_o !== 2'b00
            || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rd_basic_c3 got done=%b d=%h r=%b busy=%b want 1/deadbeef/0/0",
                     read_done_o, data_o, resp_o, busy_o);
        end
        @(negedge clk);
        n_vec++;
        if (read_done_o !== 1'b0 || data_o !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd_basic_c4 got done=%b d=%h want 0/deadbeef",
                     read_done_o, data_o);
        end
    endtask

    task automatic test_read_delayed();
        logic [63:0] a;
        int pulses, first;
        a = 64'h4000_0000_0000_0008;
        set_dly(3, 2, 0, 0, 0);
        addr_i = a; start_read_i = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_read_i = 0; addr_i = 64'h0;
            n_vec++;
            if (AR_VALID !== 1'b1 || AR_ADDR !== a) begin
                n_err++;
                $display("FAIL rd_delay_hold c%0d got v=%b a=%h want 1/%h",
                         c, AR_VALID, AR_ADDR, a);
            end
        end
        pulses = 0; first = 0;
        for (int c = 5; c <= 14; c++) begin
            @(negedge clk);
            if (read_done_o === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        n_vec++;
        if (pulses != 1 || first != 8) begin
            n_err++;
            $display("FAIL rd_delay_done got pulses=%0d at=%0d want 1 at 8",
                     pulses, first);
        end
        n_vec++;
        if (data_o !== dflt(a)) begin
            n_err++;
            $display("FAIL rd_delay_data got %h want %h", data_o, dflt(a));
        end
    endtask

    task automatic test_write_w_first();
        logic [2:0] exp_v;
        int pulses;
        set_dly(0, 0, 3, 1, 0);
        b_resp_cfg = 2'b00;
        addr_i = 64'h2000; data_i = 32'hCAFEF00D; strb_i = 4'hF;
        start_write_i = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start_write_i = 0; data_i = 32'h0; strb_i = 4'h0; addr_i = 64'h0;
            exp_v = {c <= 4, c <= 2, c == 5};
            n_vec++;
            if ({AW_VALID, W_VALID, B_READY} !== exp_v) begin
                n_err++;
                $display("FAIL wr_order c%0d got awv/wv/br=%b want %b",
                         c, {AW_VALID, W_VALID, B_READY}, exp_v);
            end
        end
        @(negedge clk);
        n_vec++;
        if (write_done_o !== 1'b1 || resp_o !== 2'b00) begin
            n_err++;
            $display("FAIL wr_done got done=%b resp=%b want 1/00", write_done_o, resp_o);
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (write_done_o === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL wr_single_pulse got %0d extra pulses want 0", pulses);
        end
        n_vec++;
        if (s_last_wa !== 64'h2000 || s_last_wd !== 32'hCAFEF00D || s_last_ws !== 4'hF) begin
            n_err++;
            $display("FAIL wr_payload got a=%h d=%h s=%h want 2000/cafef00d/f",
                     s_last_wa, s_last_wd, s_last_ws);
        end
    endtask

    task automatic test_both_starts();
        int aw0, c;
        bit seen;
        aw0 = s_aw_hs_cnt;
        set_dly(0, 2, 0, 0, 0);
        addr_i = 64'h1000; data_i = 32'h1111_2222; strb_i = 4'hF;
        start_read_i = 1; start_write_i = 1;
        @(negedge clk);
        start_read_i = 0; start_write_i = 0;
        n_vec++;
        if (AR_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL both_ar got %b want 1", AR_VALID);
        end
        seen = 0; c = 1;
        while (!seen && c < 20) begin
            if (read_done_o === 1'b1) begin
                seen = 1;
            end else begin
                n_vec++;
                if (AW_VALID !== 1'b0 || W_VALID !== 1'b0 || busy_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL both_busy c%0d got awv=%b wv=%b busy=%b want 0/0/1",
                             c, AW_VALID, W_VALID, busy_o);
                end
                @(negedge clk);
                c++;
            end
        end
        n_vec++;
        if (!seen || busy_o !== 1'b0 || data_o !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL both_done got seen=%0d busy=%b d=%h want 1/0/deadbeef",
                     seen, busy_o, data_o);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (s_aw_hs_cnt != aw0 || write_done_o !== 1'b0) begin
            n_err++;
            $display("FAIL both_no_write got aw_hs=%0d want %0d", s_aw_hs_cnt, aw0);
        end
    endtask

    task automatic test_slverr();
        bit seen;
        int c;
        set_dly(0, 0, 1, 0, 1);
        b_resp_cfg = 2'b10;
        addr_i = 64'h3000; data_i = 32'h5555_AAAA; strb_i = 4'h3;
        start_write_i = 1;
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            start_write_i = 0;
            c++;
            if (write_done_o === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || resp_o !== 2'b10 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL slverr got seen=%0d resp=%b busy=%b want 1/10/0",
                     seen, resp_o, busy_o);
        end
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
        addr_i = 64'h1000; start_read_i = 1;
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            start_read_i = 0;
            c++;
            if (read_done_o === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || c != 3 || resp_o !== 2'b00 || data_o !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL slverr_next_rd got seen=%0d lat=%0d r=%b d=%h want 1/3/00/deadbeef",
                     seen, c, resp_o, data_o);
        end
    endtask

    task automatic test_reset_mid();
        int pulses, c;
        bit seen;
        set_dly(0, 6, 0, 0, 0);
        addr_i = 64'h1000; start_read_i = 1;
        @(negedge clk);
        start_read_i = 0;
        repeat (2) @(negedge clk);
        arst_i = 1;
        #1;
        n_vec++;
        if ({AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, read_done_o,
             write_done_o, busy_o} !== 8'h00 || data_o !== 32'h0
            || resp_o !== 2'b00 || AR_ADDR !== 64'h0) begin
            n_err++;
            $display("FAIL mid_reset got ctrl=%b d=%h r=%b a=%h want 0",
                     {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, read_done_o,
                      write_done_o, busy_o}, data_o, resp_o, AR_ADDR);
        end
        @(negedge clk);
        arst_i = 0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (read_done_o === 1'b1 || busy_o === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL mid_reset_quiet got %0d active cycles want 0", pulses);
        end
        set_dly(0, 0, 0, 0, 0);
        addr_i = 64'h1000; start_read_i = 1;
        seen = 0; c = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            start_read_i = 0;
            c++;
            if (read_done_o === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || data_o !== 32'hDEADBEEF || resp_o !== 2'b00) begin
            n_err++;
            $display("FAIL mid_reset_recover got seen=%0d d=%h r=%b want 1/deadbeef/00",
                     seen, data_o, resp_o);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [31:0] d, mask, exp_d;
        logic [3:0]  s;
        logic [1:0]  rsp;
        bit          is_rd, seen;
        int          lat, exp_lat;
        smem.delete();
        mdl.delete();
        for (int i = 0; i < 60; i++) begin
            is_rd = 1'($urandom_range(0, 1));
            a = 64'h0000_00A0_0000_0000 | (64'($urandom_range(0, 7)) << 2);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            rsp = 2'($urandom_range(0, 3));
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            r_resp_cfg = rsp; b_resp_cfg = rsp;
            exp_lat = is_rd ? 3 + ar_dly + r_dly
                            : 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            exp_d = m_read(a);
            addr_i = a; data_i = d; strb_i = s;
            start_read_i = is_rd; start_write_i = !is_rd;
            seen = 0; lat = 0;
            while (!seen && lat < 40) begin
                @(negedge clk);
                lat++;
                if (lat == 1) begin
                    n_vec++;
                    if (busy_o !== 1'b1) begin
                        n_err++;
                        $display("FAIL rnd_accept #%0d got busy=%b want 1", i, busy_o);
                    end
                end
                if (read_done_o === 1'b1 || write_done_o === 1'b1) begin
                    seen = 1;
                end else begin
                    start_read_i = ($urandom_range(0, 3) == 0);
                    start_write_i = ($urandom_range(0, 3) == 0);
                    addr_i = {32'($urandom), 32'($urandom)};
                    data_i = $urandom;
                    strb_i = 4'($urandom);
                end
            end
            n_vec++;
            if (!seen) begin
                n_err++;
                $display("FAIL rnd_timeout #%0d got no done in 40 cycles want done", i);
                start_read_i = 0; start_write_i = 0;
                return;
            end
            n_vec++;
            if ({read_done_o, write_done_o} !== {is_rd, !is_rd} || lat != exp_lat
                || resp_o !== rsp) begin
                n_err++;
                $display("FAIL rnd_done #%0d got rd/wr=%b lat=%0d resp=%b want %b/%0d/%b",
                         i, {read_done_o, write_done_o}, lat, resp_o,
                         {is_rd, !is_rd}, exp_lat, rsp);
            end
            if (is_rd) begin
                n_vec++;
                if (data_o !== exp_d) begin
                    n_err++;
                    $display("FAIL rnd_rdata #%0d addr=%h got %h want %h",
                             i, a, data_o, exp_d);
                end
            end else begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                mdl[a] = (m_read(a) & ~mask) | (d & mask);
            end
            if ($urandom_range(0, 2) == 0) begin
                start_read_i = 0; start_write_i = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        start_read_i = 0; start_write_i = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_read_basic();
        test_read_delayed();
        test_write_w_first();
        test_both_starts();
        test_slverr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
